// File: rtl/xor_share_pkg.sv
// Shared types and helpers for the single-gate word XOR arbiter.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FSM state enum, index-width helpers, and the round-robin picker rr_pick.
package xor_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Upper bound on requester count accepted by rr_pick; callers zero-extend req.
    localparam int unsigned RR_MAX_NREQ = 64;
    localparam int unsigned RR_IDX_W    = 6;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First asserted request strictly after ptr, wrapping modulo nreq.
    // ptr itself is the last candidate visited, so a lone requester can win again.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_NREQ-1:0] req,
                                         input int unsigned            ptr,
                                         input int unsigned            nreq);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_NREQ; k++) begin
            cand = (ptr + k) % nreq;
            if ((k <= nreq) && !res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = RR_IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xor_bit.sv
// Single two-input XOR cell; the only XOR gate in the arbiter datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: input1, input2 -> op = input1 ^ input2.
module xor_bit (
    input  logic input1,
    input  logic input2,
    output logic op
);

    assign op = input1 ^ input2;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter that serialises word-wide XOR requests through one xor_bit cell.
// Latency: grant at the request edge E0, done pulse in the cycle after E0+WIDTH, idle again at E0+WIDTH+1.
// Backpressure: req is a level; only sampled in IDLE, losers simply wait with req held.
// Ports: clk/rst (sync, active-high), req/a_in/b_in per requester (packed i*WIDTH),
//        gnt one-hot, busy, result/done/done_id for the finished word.
module xor_share_arbiter
    import xor_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic [WIDTH-1:0]          result,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id
);

    localparam int IDW = idx_width(NREQ);
    localparam int CW  = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sha_q, sha_d;
    logic [WIDTH-1:0]  shb_q, shb_d;
    logic [WIDTH-1:0]  shr_q, shr_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [IDW-1:0]    done_id_q, done_id_d;

    logic [RR_MAX_NREQ-1:0] req_ext;
    rr_pick_t               pick;
    logic [IDW-1:0]         win_idx;
    logic                   last_bit;
    logic                   xor_op;

    assign req_ext  = RR_MAX_NREQ'(req);
    assign pick     = rr_pick(req_ext, 32'(ptr_q), NREQ);
    assign win_idx  = IDW'(pick.idx);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // The shared gate always sees the current LSBs; its output is only used in SHIFT.
    xor_bit u_xor_bit (
        .input1 (sha_q[0]),
        .input2 (shb_q[0]),
        .op     (xor_op)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            cnt_q     <= '0;
            sha_q     <= '0;
            shb_q     <= '0;
            shr_q     <= '0;
            result_q  <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sha_q     <= sha_d;
            shb_q     <= shb_d;
            shr_q     <= shr_d;
            result_q  <= result_d;
            done_id_q <= done_id_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick.found) state_d = SHIFT;
            SHIFT:   if (last_bit)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-values: capture on grant, shift one bit per SHIFT cycle.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sha_d     = sha_q;
        shb_d     = shb_q;
        shr_d     = shr_q;
        result_d  = result_q;
        done_id_d = done_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    ptr_d = win_idx;
                    cnt_d = '0;
                    sha_d = a_in[win_idx*WIDTH +: WIDTH];
                    shb_d = b_in[win_idx*WIDTH +: WIDTH];
                end
            end
            SHIFT: begin
                sha_d            = sha_q >> 1;
                shb_d            = shb_q >> 1;
                // LSB-first input: each new bit enters at the MSB so that after
                // WIDTH shifts bit 0 has walked down to position 0.
                shr_d            = shr_q >> 1;
                shr_d[WIDTH-1]   = xor_op;
                cnt_d            = cnt_q + CW'(1);
                if (last_bit) begin
                    result_d  = shr_d;
                    done_id_d = ptr_q;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; ptr_q holds the owner for the whole transaction.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            SHIFT: begin
                busy       = 1'b1;
                gnt[ptr_q] = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                gnt[ptr_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign result  = result_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter with an expected-result scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_xor_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [WIDTH-1:0]  result;
    logic              done;
    logic [1:0]        done_id;

    typedef struct {
        logic [1:0] id;
        logic [7:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;

    logic [7:0] av [4];
    logic [7:0] bv [4];

    xor_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .result  (result),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_id", 32'(done_id), 32'(e.id));
                check("result", 32'(result), 32'(e.res));
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id  = id;
        e.res = a ^ b;
        sb.push_back(e);
    endtask

    // Returns at negedge+1 of the next done pulse, or after budget cycles.
    task automatic wait_done(input string tag, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        logic seen_g1;
        int saved_cnt;

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        av = '{8'h11, 8'h22, 8'h33, 8'h44};
        bv = '{8'hF0, 8'h0F, 8'hCC, 8'h55};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Truth table: 0C ^ 0A covers all four bit combinations
        set_op(0, 8'h0C, 8'h0A);
        push_exp(2'd0, 8'h0C, 8'h0A);
        req = 4'b0001;
        @(posedge clk); #1 req = '0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk); #1;
            check($sformatf("t1_gnt%0d", k), 32'(gnt), (k <= 8) ? 32'd1 : 32'd0);
            check($sformatf("t1_busy%0d", k), 32'(busy), (k <= 8) ? 32'd1 : 32'd0);
            check($sformatf("t1_done%0d", k), 32'(done), (k == 8) ? 32'd1 : 32'd0);
        end
        check("t1_result_held", 32'(result), 32'h06);

        // Full word on requester 2; operand change during SHIFT must be ignored
        @(posedge clk); #1;
        set_op(2, 8'hA5, 8'h0F);
        push_exp(2'd2, 8'hA5, 8'h0F);
        req = 4'b0100;
        @(posedge clk); #1 req = '0;
        repeat (3) @(posedge clk);
        #1 a_in[23:16] = 8'hFF;
        check("t2_gnt_mid", 32'(gnt), 32'b0100);
        wait_done("t2_done", 20);

        // Pointer wrap: with ptr=2, requester 3 wins over 0
        @(posedge clk); #1;
        set_op(3, 8'h3C, 8'hC3);
        set_op(0, 8'h12, 8'h34);
        push_exp(2'd3, 8'h3C, 8'hC3);
        push_exp(2'd0, 8'h12, 8'h34);
        req = 4'b1001;
        wait_done("t3_first", 20);
        req = 4'b0001;
        wait_done("t3_second", 24);
        req = '0;

        // Fairness: all requesters held high from reset
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, av[i], bv[i]);
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(2'(i), av[i], bv[i]);
        push_exp(2'd0, av[0], bv[0]);
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_done($sformatf("t4_done%0d", n), 30);
            if (n > 0) check($sformatf("t4_spacing%0d", n), 32'(last_done_cyc - prev), 32'd10);
            prev = last_done_cyc;
        end
        req = '0;

        // Reset mid-operation aborts without a done pulse
        @(posedge clk); #1;
        set_op(1, 8'h96, 8'h69);
        req = 4'b0010;
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_result", 32'(result), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        saved_cnt = done_cnt;
        repeat (12) @(negedge clk);
        #1 check("t5_no_done", 32'(done_cnt - saved_cnt), 32'd0);
        set_op(1, 8'h3C, 8'h5A);
        push_exp(2'd1, 8'h3C, 8'h5A);
        @(posedge clk); #1 req = 4'b0010;
        @(posedge clk); #1 req = '0;
        wait_done("t5_done_after", 20);

        // One-cycle pulse on req[1] while busy is never granted
        @(posedge clk); #1;
        set_op(0, 8'hF0, 8'hAA);
        push_exp(2'd0, 8'hF0, 8'hAA);
        req = 4'b0001;
        @(posedge clk); #1 req = '0;
        repeat (2) @(posedge clk);
        #1 req = 4'b0010;
        @(posedge clk); #1 req = '0;
        seen_g1 = 1'b0;
        saved_cnt = done_cnt;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); #1;
            if (gnt[1] === 1'b1) seen_g1 = 1'b1;
        end
        check("t6_never_g1", 32'(seen_g1), 32'd0);
        check("t6_one_done", 32'(done_cnt - saved_cnt), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
